seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
Stimulus-side serializer for the 1011 sequence-detector environment. It accepts parallel words over a valid/ready handshake and shifts them out MSB-first as a serial bit stream that drives the detector's din. It also tracks the transmitted stream itself and flags every overlapping 1011 occurrence. This gives the scoreboard a cycle-exact golden expectation for dout.

Parameters:
WIDTH, 8, bits per parallel word (min 1)
GAP_CYCLES, 0, idle cycles inserted after each word (ser_valid low)
CNT_W, 16, width of saturating match counter

Ports:
clk  input  1  system clock, all logic on posedge
rstn  input  1  asynchronous active-low reset
in_valid  input  1  parallel word offered
in_ready  output  1  block can accept a word this cycle
in_data  input  WIDTH  word to serialize, MSB transmitted first
ser_out  output  1  serial bit, connects to detector din
ser_valid  output  1  ser_out carries a real bit this cycle
busy  output  1  high in SHIFT or GAP
exp_match  output  1  pulse: current ser_out bit completes 1011 with the prior three valid bits
match_cnt  output  CNT_W  total exp_match pulses, saturating
clr_cnt  input  1  synchronous clear of match_cnt

Behaviour:
- Reset (async, rstn low): state IDLE; in_ready=1; ser_out=0, ser_valid=0, busy=0, exp_match=0, match_cnt=0, bit history=0. A word in flight is dropped. Output ser_out/ser_valid is registered.
- Handshake: word accepted when in_valid && in_ready. in_data sampled in that cycle. Holding in_valid without in_ready has no effect.
- States IDLE, SHIFT, GAP:
  - IDLE: in_ready=1. On accept: SHIFT.
  - SHIFT: outputs one bit per cycle. The accepted word's MSB appears on ser_out with ser_valid=1 on the cycle after accept, so latency is 1 cycle. Bit index counts WIDTH-1 down to 0.
  - On the last bit (index 0):
    - GAP_CYCLES=0: in_ready=1. If a word is accepted, stay in SHIFT and emit the new MSB on the next cycle, with no bubble. Otherwise go to IDLE.
    - GAP_CYCLES>0: go to GAP, in_ready=0.
  - GAP: ser_valid=0, ser_out=0, for exactly GAP_CYCLES cycles, then IDLE.
- in_ready=0 in SHIFT (except the last bit with GAP_CYCLES=0) and in GAP. busy is high in SHIFT and GAP.
- Match tracking:
  - A 4-bit history shifts only on cycles with ser_valid=1, so idle/gap cycles do not break a pattern.
  - History persists across words; only rstn clears it.
  - exp_match is registered and aligned with the ser_out bit that completes {h[2:0], ser_out}==4'b1011. Overlapping occurrences count.
- match_cnt:
  - Increments on exp_match and saturates at all-ones.
  - clr_cnt has priority: if clr_cnt and exp_match occur together, match_cnt becomes 0.
- Undefined in_data bits are not checked. in_data may change freely when no handshake occurs.

Decomposition:
- Package seq_pkg:
  - PATTERN = 4'b1011, PAT_LEN = 4
  - typedef enum {IDLE, SHIFT, GAP} tx_state_t
- Sub-module seq_match_tracker: history shift register, exp_match, and saturating match_cnt/clr_cnt logic. It is reusable by the monitor-side reference model.

Test Plan:
- Single word, WIDTH=8, GAP=0: in_data=8'hB6 -> ser_out over cycles 1..8 = 1,0,1,1,0,1,1,0; exp_match high on bits 4 and 7; match_cnt=2; in_ready low on cycles 1..7.
- Back-to-back, GAP=0: 8'h01 then 8'h60 with in_valid held -> 16 contiguous ser_valid cycles with no bubble; exactly one exp_match, on bit 3 of the second word (cross-word 1011); match_cnt=1.
- GAP_CYCLES=2: 8'h01 then 8'h60 -> 2 ser_valid=0 cycles between words; the cross-word match is still flagged; in_ready low during the gap.
- Reset mid-word: assert rstn low on bit 5 of 8'hB6 -> all outputs 0 immediately; after release in_ready=1, history cleared; a following 8'h0B gives a match on bit 8 only.
- Counter: CNT_W=2 with 4 matches -> match_cnt saturates at 3. clr_cnt on the same cycle as a match -> match_cnt=0.
- Backpressure: in_valid asserted during SHIFT with GAP=0 on a non-final bit -> no acceptance; the word is accepted only on the final-bit cycle, and in_data is sampled then.

Source files
------------

// File: rtl/seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_pkg : shared pattern constants and TX state encoding for seq_pattern_tx
// Rev 1.0
// ----------------------------------------------------------------------------
package seq_pkg;

  localparam int                 PAT_LEN = 4;
  localparam logic [PAT_LEN-1:0] PATTERN = 4'b1011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_match_tracker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_match_tracker : overlapping PATTERN detector on a qualified bit stream
// Rev 1.0
// ----------------------------------------------------------------------------
module seq_match_tracker
  import seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             clr_cnt,
  output logic             exp_match,
  output logic [CNT_W-1:0] match_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Only the older PAT_LEN-1 bits are stored; the incoming bit completes the window.
  logic [PAT_LEN-2:0] r_hist;
  logic [PAT_LEN-1:0] w_window;

  assign w_window = {r_hist, bit_in};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_hist    <= '0;
      exp_match <= 1'b0;
    end else begin
      exp_match <= bit_valid && (w_window == PATTERN);
      if (bit_valid) begin
        r_hist <= w_window[PAT_LEN-2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      match_cnt <= '0;
    end else if (clr_cnt) begin
      match_cnt <= '0;
    end else if (exp_match && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_pattern_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// seq_pattern_tx : MSB-first word serializer with golden 1011 match tracking
// Rev 1.0
// ----------------------------------------------------------------------------
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             exp_match,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             clr_cnt
);

  localparam int               IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int               GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP    = IDX_W'(WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_TOP    = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic             NO_GAP     = (GAP_CYCLES == 0);
  localparam logic             LOAD_READY = NO_GAP && (WIDTH == 1);

  tx_state_t        r_state;
  logic [IDX_W-1:0] r_idx;
  logic [GAP_W-1:0] r_gap;
  logic [WIDTH-1:0] r_shift;

  logic w_accept;
  logic w_last;
  logic w_nxt_valid;
  logic w_nxt_bit;

  assign w_accept    = in_valid && in_ready;
  assign w_last      = (r_state == SHIFT) && (r_idx == '0);
  assign w_nxt_valid = w_accept || ((r_state == SHIFT) && !w_last);
  // r_shift is kept MSB-aligned: its top bit is always the next bit to send.
  assign w_nxt_bit   = w_accept ? in_data[WIDTH-1] : (w_nxt_valid && r_shift[WIDTH-1]);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_gap     <= '0;
      r_shift   <= '0;
      in_ready  <= 1'b1;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ser_out   <= w_nxt_bit;
      ser_valid <= w_nxt_valid;
      // in_ready is only high in IDLE or on a gapless final bit, so accept
      // always (re)starts a word regardless of the current state.
      if (w_accept) begin
        r_state  <= SHIFT;
        r_idx    <= IDX_TOP;
        r_shift  <= in_data << 1;
        in_ready <= LOAD_READY;
        busy     <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
          SHIFT: begin
            if (!w_last) begin
              r_idx    <= r_idx - IDX_W'(1);
              r_shift  <= r_shift << 1;
              in_ready <= NO_GAP && (r_idx == IDX_W'(1));
            end else if (NO_GAP) begin
              r_state  <= IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              r_state  <= GAP;
              r_gap    <= GAP_TOP;
              in_ready <= 1'b0;
            end
          end
          GAP: begin
            if (r_gap == '0) begin
              r_state  <= IDLE;
              in_ready <= 1'b1;
              busy     <= 1'b0;
            end else begin
              r_gap <= r_gap - GAP_W'(1);
            end
          end
          default: begin
            r_state  <= IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

  // The tracker sees the bit being registered, so exp_match lands with ser_out.
  seq_match_tracker #(
    .CNT_W(CNT_W)
  ) u_tracker (
    .clk      (clk),
    .rstn     (rstn),
    .bit_valid(w_nxt_valid),
    .bit_in   (w_nxt_bit),
    .clr_cnt  (clr_cnt),
    .exp_match(exp_match),
    .match_cnt(match_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_seq_pattern_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_seq_pattern_tx : scoreboard bench, one gapless and one gapped instance
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_seq_pattern_tx;

  logic        clk;
  logic        rst0_n, rst1_n;
  logic        v0, v1, rdy0, rdy1;
  logic [7:0]  d0, d1;
  logic        so0, so1, sv0, sv1, busy0, busy1, em0, em1, clr0, clr1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int total = 0;
  int bad   = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] e0, e1;

  seq_pattern_tx #(.WIDTH(8), .GAP_CYCLES(0), .CNT_W(16)) dut0 (
    .clk(clk), .rstn(rst0_n), .in_valid(v0), .in_ready(rdy0), .in_data(d0),
    .ser_out(so0), .ser_valid(sv0), .busy(busy0), .exp_match(em0),
    .match_cnt(cnt0), .clr_cnt(clr0)
  );

  seq_pattern_tx #(.WIDTH(8), .GAP_CYCLES(2), .CNT_W(2)) dut1 (
    .clk(clk), .rstn(rst1_n), .in_valid(v1), .in_ready(rdy1), .in_data(d1),
    .ser_out(so1), .ser_valid(sv1), .busy(busy1), .exp_match(em1),
    .match_cnt(cnt1), .clr_cnt(clr1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Expected stream entry = {bit, match}; mask bit i marks a hand-computed match on data[i].
  task automatic push_word(input int which, input logic [7:0] data, input logic [7:0] mask);
    for (int i = 7; i >= 0; i--) begin
      if (which == 0) q0.push_back({data[i], mask[i]});
      else            q1.push_back({data[i], mask[i]});
    end
  endtask

  function automatic logic ready_of(input int which);
    return (which == 0) ? rdy0 : rdy1;
  endfunction

  function automatic int qsize(input int which);
    return (which == 0) ? q0.size() : q1.size();
  endfunction

  task automatic drive_word(input int which, input logic [7:0] data);
    int n;
    n = 0;
    if (which == 0) begin v0 = 1'b1; d0 = data; end
    else            begin v1 = 1'b1; d1 = data; end
    while (!ready_of(which) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("accept_timeout_cycles", n, 0);
    @(posedge clk);
    #1;
    if (which == 0) v0 = 1'b0;
    else            v1 = 1'b0;
  endtask

  task automatic drain(input int which);
    int n;
    n = 0;
    while (qsize(which) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail_now("drain_left_bits", qsize(which), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_reset(input int which);
    @(negedge clk);
    #2;
    if (which == 0) rst0_n = 1'b0;
    else            rst1_n = 1'b0;
    @(negedge clk);
    if (which == 0) begin q0.delete(); rst0_n = 1'b1; end
    else            begin q1.delete(); rst1_n = 1'b1; end
  endtask

  always @(negedge clk) begin
    if (rst0_n) begin
      if (sv0) begin
        if (q0.size() == 0) fail_now("dut0_unexpected_bit", 1, 0);
        else begin
          e0 = q0.pop_front();
          check("dut0_ser_out", so0, e0[1]);
          check("dut0_exp_match", em0, e0[0]);
        end
      end else begin
        check("dut0_idle_exp_match", em0, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst1_n) begin
      if (sv1) begin
        if (q1.size() == 0) fail_now("dut1_unexpected_bit", 1, 0);
        else begin
          e1 = q1.pop_front();
          check("dut1_ser_out", so1, e1[1]);
          check("dut1_exp_match", em1, e1[0]);
        end
      end else begin
        check("dut1_idle_exp_match", em1, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nv;
    int gapc;
    int n;
    rst0_n = 1'b0; rst1_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; clr0 = 1'b0; clr1 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready0", rdy0, 1);
    check("rst_ser_out0", so0, 0);
    check("rst_ser_valid0", sv0, 0);
    check("rst_busy0", busy0, 0);
    check("rst_exp_match0", em0, 0);
    check("rst_match_cnt0", cnt0, 0);
    check("rst_in_ready1", rdy1, 1);
    check("rst_ser_valid1", sv1, 0);
    check("rst_busy1", busy1, 0);
    check("rst_match_cnt1", cnt1, 0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);

    // Single word B6: matches on bits 4 and 7, ready only on the last bit.
    push_word(0, 8'hB6, 8'h12);
    drive_word(0, 8'hB6);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_in_ready", rdy0, (i == 7));
      check("t1_busy", busy0, 1);
    end
    drain(0);
    check("t1_match_cnt", cnt0, 2);
    check("t1_busy_after", busy0, 0);

    // Back-to-back 01,60 with valid held: no bubble, cross-word match.
    pulse_reset(0);
    push_word(0, 8'h01, 8'h00);
    push_word(0, 8'h60, 8'h20);
    v0 = 1'b1; d0 = 8'h01;
    @(posedge clk);
    #1;
    d0 = 8'h60;
    nv = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (sv0) nv++;
      if (i == 7) begin
        check("t2_last_bit_ready", rdy0, 1);
        @(posedge clk);
        #1;
        v0 = 1'b0;
      end
    end
    check("t2_contiguous_valid", nv, 16);
    drain(0);
    check("t2_match_cnt", cnt0, 1);

    // Backpressure: decoy data while not ready, real word only on final bit.
    pulse_reset(0);
    push_word(0, 8'h00, 8'h00);
    push_word(0, 8'h0B, 8'h01);
    v0 = 1'b1; d0 = 8'h00;
    @(posedge clk);
    #1;
    d0 = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i < 7) check("t3_ready_low", rdy0, 0);
      else begin
        check("t3_ready_final", rdy0, 1);
        d0 = 8'h0B;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        d0 = 8'hFF;
      end
    end
    drain(0);
    check("t3_match_cnt", cnt0, 1);

    // Reset on bit 5 of B6, then 0B must match only on its last bit.
    push_word(0, 8'hB6, 8'h12);
    drive_word(0, 8'hB6);
    repeat (5) @(negedge clk);
    #2;
    rst0_n = 1'b0;
    #1;
    check("t4_async_ser_out", so0, 0);
    check("t4_async_ser_valid", sv0, 0);
    check("t4_async_busy", busy0, 0);
    check("t4_async_exp_match", em0, 0);
    check("t4_async_match_cnt", cnt0, 0);
    check("t4_async_in_ready", rdy0, 1);
    q0.delete();
    @(negedge clk);
    rst0_n = 1'b1;
    check("t4_ready_after", rdy0, 1);
    push_word(0, 8'h0B, 8'h01);
    drive_word(0, 8'h0B);
    drain(0);
    check("t4_match_cnt", cnt0, 1);

    // Gapped instance: two idle cycles after each word, cross-word match kept.
    push_word(1, 8'h01, 8'h00);
    push_word(1, 8'h60, 8'h20);
    v1 = 1'b1; d1 = 8'h01;
    @(posedge clk);
    #1;
    d1 = 8'h60;
    gapc = 0;
    n = 0;
    while (!rdy1 && n < 50) begin
      @(negedge clk);
      n++;
      if (busy1 && !sv1) gapc++;
    end
    if (n >= 50) fail_now("t5_ready_timeout", n, 0);
    check("t5_idle_at_ready", busy1, 0);
    @(posedge clk);
    #1;
    v1 = 1'b0;
    drain(1);
    check("t5_gap_cycles", gapc, 2);
    check("t5_match_cnt", cnt1, 1);

    // 2-bit counter: 1 + 2 + 2 matches saturates at 3.
    push_word(1, 8'hB6, 8'h12);
    drive_word(1, 8'hB6);
    drain(1);
    check("t6_match_cnt_3", cnt1, 3);
    push_word(1, 8'hB6, 8'h12);
    drive_word(1, 8'hB6);
    drain(1);
    check("t6_match_cnt_sat", cnt1, 3);

    // clr_cnt coinciding with the bit-7 match wins.
    push_word(1, 8'hB6, 8'h12);
    drive_word(1, 8'hB6);
    repeat (7) @(negedge clk);
    check("t7_match_present", em1, 1);
    clr1 = 1'b1;
    @(posedge clk);
    #1;
    clr1 = 1'b0;
    drain(1);
    check("t7_match_cnt_cleared", cnt1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
